// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory path: core request/response bundles
// and the controller state encoding.
package definitions;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        BUSY,
        RESP
    } dmem_ctrl_state_e;

    localparam int dmem_lane_w_gp = 2;

    // Byte-enable mask: all lanes for a word, one lane for a byte.
    function automatic logic [3:0] lane_be(
        input logic                      byte_not_word,
        input logic [dmem_lane_w_gp-1:0] lane
    );
        return byte_not_word ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_array.sv
// dmem_array: 2**addr_width_p x 32 storage, byte-enabled synchronous write,
// asynchronous read, no reset. Ports: clk, we, be, addr, wdata, rdata.
module dmem_array #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [3:0]              be,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [2**addr_width_p];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: valid/yumi data-memory controller with programmable latency.
// Ports: clk, n_reset, to_mem_i (core request), addr_i (byte address),
// from_mem_o (response), misaligned_o (pulse on misaligned word accept).
module data_mem_ctrl
    import definitions::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic     clk,
    input  logic     n_reset,
    input  mem_in_s  to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s from_mem_o,
    output logic     misaligned_o
);

    localparam int CW = (latency_p > 1) ? $clog2(latency_p + 1) : 1;
    localparam int AW = addr_width_p + dmem_lane_w_gp;

    dmem_ctrl_state_e state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic          wen_q;
    logic          bnw_q;
    logic [31:0]   wd_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   rd_q;

    logic accept;
    logic load_cnt;
    logic dec_cnt;
    logic capture;
    logic arr_we;
    logic yumi_o;
    logic valid_o;

    logic [dmem_lane_w_gp-1:0] lane;
    logic [31:0] arr_rdata;
    logic [31:0] arr_wdata;
    logic [3:0]  arr_be;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;

    // Bits above the array span are intentionally dropped (address wrap).
    logic unused_addr;
    assign unused_addr = ^addr_i[31:AW];

    // Word ops are forced to lane 0, which also aligns misaligned words down.
    assign lane = bnw_q ? addr_q[dmem_lane_w_gp-1:0] : '0;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        capture  = 1'b0;
        arr_we   = 1'b0;
        yumi_o   = 1'b0;
        valid_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (to_mem_i.valid) begin
                    accept  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                yumi_o   = 1'b1;
                arr_we   = wen_q;
                load_cnt = 1'b1;
                if (latency_p == 0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                dec_cnt = 1'b1;
                if (cnt_q == CW'(1)) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                valid_o = 1'b1;
                if (to_mem_i.yumi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q  <= '0;
            wen_q  <= 1'b0;
            bnw_q  <= 1'b0;
            wd_q   <= '0;
            addr_q <= '0;
            rd_q   <= '0;
        end else begin
            if (accept) begin
                wen_q  <= to_mem_i.wen;
                bnw_q  <= to_mem_i.byte_not_word;
                wd_q   <= to_mem_i.write_data;
                addr_q <= addr_i[AW-1:0];
            end
            if (load_cnt) begin
                cnt_q <= CW'(latency_p);
            end else if (dec_cnt) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (capture) begin
                rd_q <= ld_data;
            end
        end
    end

    assign arr_be    = lane_be(bnw_q, lane);
    assign arr_wdata = bnw_q ? {4{wd_q[7:0]}} : wd_q;
    assign ld_byte   = arr_rdata[{lane, 3'b000} +: 8];

    // Stores answer with zero data; byte loads are zero-extended.
    always_comb begin
        ld_data = '0;
        if (!wen_q) begin
            ld_data = bnw_q ? {24'h0, ld_byte} : arr_rdata;
        end
    end

    dmem_array #(
        .addr_width_p(addr_width_p)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (addr_q[AW-1:dmem_lane_w_gp]),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign from_mem_o.read_data = rd_q;
    assign from_mem_o.valid     = valid_o;
    assign from_mem_o.yumi      = yumi_o;

    assign misaligned_o = (state_q == ACK) && !bnw_q &&
                          (addr_q[dmem_lane_w_gp-1:0] != '0);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (latency 2 and 0) checked against
// a word-addressed memory model with directed and random accesses.
module tb_data_mem_ctrl;
    import definitions::*;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    mem_in_s  [1:0]       req;
    logic     [1:0][31:0] addr;
    mem_out_s [1:0]       rsp;
    logic     [1:0]       mis;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [int];
    int unsigned wa [8];

    data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) u_dut2 (
        .clk          (clk),
        .n_reset      (n_reset),
        .to_mem_i     (req[0]),
        .addr_i       (addr[0]),
        .from_mem_o   (rsp[0]),
        .misaligned_o (mis[0])
    );

    data_mem_ctrl #(.addr_width_p(10), .latency_p(0)) u_dut0 (
        .clk          (clk),
        .n_reset      (n_reset),
        .to_mem_i     (req[1]),
        .addr_i       (addr[1]),
        .from_mem_o   (rsp[1]),
        .misaligned_o (mis[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Model key: instance plus word index modulo 1024 words.
    function automatic int key(input int i, input logic [31:0] a);
        return i * 4096 + int'((a / 4) % 1024);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction; entered and left on a negedge in an IDLE cycle.
    task automatic access(input int i, input bit w, input bit b,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int stall, input string tag);
        logic [31:0] exp;
        int k, l, cyc;
        k = key(i, a);
        l = int'(a % 4);
        if (w) begin
            exp = 32'h0;
            if (b) begin
                mdl[k] = (mdl[k] & ~(32'hff << (8 * l))) |
                         ({24'h0, wd[7:0]} << (8 * l));
            end else begin
                mdl[k] = wd;
            end
        end else begin
            exp = b ? ((mdl[k] >> (8 * l)) & 32'hff) : mdl[k];
        end
        req[i].valid         = 1'b1;
        req[i].wen           = w;
        req[i].byte_not_word = b;
        req[i].write_data    = wd;
        addr[i]              = a;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".yumi"}, 64'(rsp[i].yumi), 64'd1);
        chk({tag, ".mis"}, 64'(mis[i]), 64'(!b && (a % 4) != 0));
        cyc = 1;
        while (rsp[i].valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            req[i].valid = 1'b0;
            cyc++;
            if (rsp[i].valid !== 1'b1) begin
                chk({tag, ".busy"}, 64'({rsp[i].yumi, mis[i]}), 64'd0);
            end
        end
        req[i].valid = 1'b0;
        chk({tag, ".lat"}, 64'(cyc), 64'(2 + lat(i)));
        chk({tag, ".ry"}, 64'(rsp[i].yumi), 64'd0);
        chk({tag, ".data"}, 64'(rsp[i].read_data), 64'(exp));
        for (int s = 0; s < stall; s++) begin
            req[i].yumi = (s % 2 == 0) ? 1'b0 : 1'b0;
            @(negedge clk);
            chk({tag, ".hold"}, 64'({rsp[i].valid, rsp[i].read_data}),
                64'({1'b1, exp}));
        end
        req[i].yumi = 1'b1;
        @(negedge clk);
        req[i].yumi = 1'b0;
        chk({tag, ".idle"}, 64'({rsp[i].valid, rsp[i].yumi}), 64'd0);
    endtask

    initial begin
        req     = '0;
        addr    = '0;
        n_reset = 1'b1;
        #2 n_reset = 1'b0;
        @(negedge clk);
        chk("reset", 64'({rsp, mis}), 64'd0);
        n_reset = 1'b1;
        @(negedge clk);

        access(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, "st_w");
        access(0, 0, 0, 32'h10, 32'h0, 0, "ld_w");
        access(0, 1, 0, 32'h20, 32'h11223344, 0, "st_w20");
        access(0, 1, 1, 32'h22, 32'h000000AA, 0, "st_b22");
        access(0, 0, 0, 32'h20, 32'h0, 0, "ld_w20");
        access(0, 0, 1, 32'h22, 32'h0, 0, "ld_b22");
        chk("merge", 64'(mdl[key(0, 32'h20)]), 64'h11AA3344);
        access(0, 0, 0, 32'h20, 32'h0, 5, "bp");

        access(1, 1, 0, 32'h10, 32'h55667788, 0, "z_st");
        access(1, 0, 0, 32'h10, 32'h0, 0, "z_ld0");
        access(1, 0, 1, 32'h11, 32'h0, 0, "z_ld1");
        access(1, 0, 0, 32'h13, 32'h0, 0, "z_mis");

        access(0, 1, 0, 32'h10, 32'h55667788, 0, "st_m");
        access(0, 0, 0, 32'h13, 32'h0, 0, "ld_mis");

        // Reset while BUSY after the store's ACK edge: data must persist.
        access(0, 1, 0, 32'h40, 32'h01010101, 0, "st40a");
        req[0] = '0;
        req[0].valid = 1'b1;
        req[0].wen = 1'b1;
        req[0].write_data = 32'hCAFEF00D;
        addr[0] = 32'h40;
        @(posedge clk);
        @(negedge clk);
        chk("rb.ack", 64'(rsp[0].yumi), 64'd1);
        @(negedge clk);
        req[0].valid = 1'b0;
        chk("rb.busy", 64'({rsp[0].valid, rsp[0].yumi}), 64'd0);
        #2 n_reset = 1'b0;
        #1 chk("rb.out", 64'({rsp, mis}), 64'd0);
        mdl[key(0, 32'h40)] = 32'hCAFEF00D;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        access(0, 0, 0, 32'h40, 32'h0, 0, "ld40");

        // Reset during the ACK cycle: store must be dropped.
        access(0, 1, 0, 32'h44, 32'h12345678, 0, "st44a");
        req[0].valid = 1'b1;
        req[0].wen = 1'b1;
        req[0].write_data = 32'h99999999;
        addr[0] = 32'h44;
        @(posedge clk);
        @(negedge clk);
        chk("ra.ack", 64'(rsp[0].yumi), 64'd1);
        #2 n_reset = 1'b0;
        req[0].valid = 1'b0;
        #1 chk("ra.out", 64'({rsp, mis}), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        access(0, 0, 0, 32'h44, 32'h0, 0, "ld44");

        // Random traffic over a seeded word set, with aliased high bits.
        for (int j = 0; j < 8; j++) begin
            wa[j] = $urandom_range(1023);
            for (int i = 0; i < 2; i++) begin
                access(i, 1, 0, (wa[j] * 4) | ($urandom << 12),
                       $urandom, 0, "seed");
            end
        end
        for (int n = 0; n < 60; n++) begin
            int i, j;
            i = $urandom_range(1);
            j = $urandom_range(7);
            access(i, 1'($urandom_range(1)), 1'($urandom_range(1)),
                   (wa[j] * 4) | ($urandom << 12) | $urandom_range(3),
                   $urandom, $urandom_range(2), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
